io_mem_slave: RTL

IO_MEM_SLAVE -- requirements
Module: io_mem_slave

---
 rtl/io_mem_pkg.sv | 19 +
 rtl/io_mem_array.sv | 35 +++
 rtl/io_mem_slave.sv | 123 ++++++++++++
 3 files changed

// File: rtl/io_mem_pkg.sv
// Shared types and default parameter values for the io_mem_slave bus target.
package io_mem_pkg;

  localparam int DEF_ADDR_W      = 20;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_MEM_AW      = 12;
  localparam int DEF_SPACE       = 1;
  localparam int DEF_WAIT_STATES = 0;

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    VALID = 6'b000010,
    WAIT  = 6'b000100,
    READ  = 6'b001000,
    WRITE = 6'b010000,
    HALT  = 6'b100000
  } state_e;

endpackage

// File: rtl/io_mem_array.sv
// Single-port storage: synchronous write, registered read. Only the read
// register is cleared by reset; the array contents are left untouched.
module io_mem_array #(
  parameter int DATA_W = 8,
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [MEM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [1 << MEM_AW];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/io_mem_slave.sv
// Address-latched bus target with optional wait states in front of a
// small memory; responds only to the configured IOM space.
module io_mem_slave
  import io_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MEM_AW      = DEF_MEM_AW,
  parameter int SPACE       = DEF_SPACE,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CS,
  input  logic              ALE,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOE,
  output logic              READY
);

  localparam logic       SPACE_BIT = 1'(SPACE);
  localparam logic [3:0] WS_LAST   = 4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_rd_q, op_rd_d;
  logic              sel;
  logic              mem_we, mem_re;
  logic              unused_addr;

  // Upper address bits are deliberately dropped so the storage wraps.
  always_comb unused_addr = ^Address;

  always_comb sel = CS && (IOM == SPACE_BIT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    op_rd_d = op_rd_q;
    unique case (state_q)
      IDLE: begin
        if (ALE && sel) begin
          state_d = VALID;
          addr_d  = Address[MEM_AW-1:0];
        end
      end
      VALID: begin
        if (!RD || !WR) begin
          op_rd_d = !RD;
          cnt_d   = '0;
          if (WAIT_STATES > 0) state_d = WAIT;
          else if (!RD)        state_d = READ;
          else                 state_d = WRITE;
        end
      end
      WAIT: begin
        if (cnt_q == WS_LAST) begin
          cnt_d   = '0;
          state_d = op_rd_q ? READ : WRITE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      READ, WRITE: state_d = HALT;
      HALT: begin
        if (ALE && sel) begin
          state_d = VALID;
          addr_d  = Address[MEM_AW-1:0];
        end else if (RD && WR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      op_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      op_rd_q <= op_rd_d;
    end
  end

  // The read register loads on the edge entering READ; a write commits on
  // the edge leaving WRITE unless reset lands on that same edge.
  always_comb begin
    mem_re = (state_d == READ) && !RESET;
    mem_we = (state_q == WRITE) && !RESET;
  end

  io_mem_array #(
    .DATA_W(DATA_W),
    .MEM_AW(MEM_AW)
  ) u_array (
    .clk  (CLK),
    .rst  (RESET),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q),
    .wdata(DIN),
    .rdata(DOUT)
  );

  always_comb begin
    DOE   = (state_q == READ) || ((state_q == HALT) && op_rd_q && !RD);
    READY = (state_q != WAIT);
  end

endmodule
